pong_match_ctrl: RTL
====================

# pong_match_ctrl

Match sequencer for Speed Pong. It owns the rally lifecycle: it holds and recentres the ball between points, times the serve and post-point pauses, keeps both scores, and raises the rally speed level as paddle hits accumulate. It sits between the ball/collision datapath, which reports goals and hits, and the score display and ball mover, which consume its hold, recentre, direction and speed outputs.

## Interface
Parameters:
- WIN_SCORE, 7: points needed to win; legal range 1..9.
- SERVE_TICKS, 100: tick strobes spent in SERVE before the ball is released; legal range 1..255.
- POINT_TICKS, 60: tick strobes spent in POINT after a goal; legal range 1..255.
- HITS_PER_LEVEL, 4: paddle hits per speed-level step; legal range 1..15.

Ports:
- clk  in  1  system clock.
- resetB  in  1  asynchronous, active-low reset.
- tick  in  1  single-cycle enable strobe at the paddle/ball update rate. It is not a clock.
- start  in  1  single-cycle pulse from the debounced start button.
- goalLeft  in  1  single-cycle pulse: ball passed P1's edge, so P2 scores.
- goalRight  in  1  single-cycle pulse: ball passed P2's edge, so P1 scores.
- paddleHit  in  1  single-cycle pulse: ball bounced off either paddle.
- ballHold  out  1  ball mover frozen when 1.
- ballCenter  out  1  single-cycle pulse: reload ball to centre.
- serveDir  out  1  0 = serve toward P1 (left), 1 = serve toward P2 (right).
- speedLevel  out  2  rally speed 0..3.
- p1score, p2score  out  4  binary scores 0..9.
- winner  out  2  00 = none, 01 = P1, 10 = P2.

## Operation
- States: IDLE, SERVE, RALLY, POINT, OVER.
- IDLE: on start, go to SERVE and clear both scores.
- SERVE: on tick, decrement the timer. After the SERVE_TICKS-th tick, go to RALLY.
- RALLY:
  - paddleHit increments the hit counter.
  - When the hit counter reaches HITS_PER_LEVEL, clear it and increment speedLevel, saturating at 3.
  - goalLeft increments p2score, sets serveDir=0 and goes to POINT.
  - goalRight increments p1score, sets serveDir=1 and goes to POINT.
- POINT:
  - If either score equals WIN_SCORE, go to OVER immediately and set winner.
  - Otherwise, after POINT_TICKS ticks, go to SERVE.
- OVER: hold scores and winner. On start, clear scores, winner, speedLevel and the hit counter, set serveDir=1, and go to SERVE.
- Entering SERVE, from any predecessor:
  - pulse ballCenter for exactly 1 cycle;
  - load the timer with SERVE_TICKS;
  - clear speedLevel and the hit counter.
- ballHold = 1 in every state except RALLY.
- Simultaneous events:
  - goalLeft and goalRight in the same cycle: goalLeft wins, goalRight is dropped.
  - A goal in the same cycle as paddleHit: the goal wins, the hit is dropped.
- Goals and hits outside RALLY are ignored. start outside IDLE/OVER is ignored.
- Scores never exceed WIN_SCORE, because the game ends there.

## Timing
- Reset values: state IDLE, ballHold=1, ballCenter=0, serveDir=1, speedLevel=0, scores 0, winner=00, timer 0, hit counter 0.
- All outputs are registered. State and outputs update on the clk edge that samples the triggering input, so the response is visible 1 cycle after the input pulse.
- SERVE lasts exactly SERVE_TICKS tick strobes. The RALLY entry edge is the edge that samples the last tick.
- POINT lasts exactly POINT_TICKS tick strobes when the game is not won.
- The score increment and the POINT entry occur on the same edge.
- OVER entry is 1 cycle after POINT entry.
- tick asserted in the cycle a state is entered does not count toward that state's timer.
- Reset asserted mid-operation returns every output to its reset value asynchronously. The first state change after reset release requires start.

## Structure
- pong_pkg holds:
  - the match_state_t enum (IDLE, SERVE, RALLY, POINT, OVER);
  - the SERVE_LEFT and SERVE_RIGHT constants;
  - the winner encodings.
- One sub-module, tick_timer: an 8-bit loadable down-counter with load, enable (tick) and a done flag. It is instantiated once and reloaded on each SERVE or POINT entry.

## Test plan
- Reset, then start, with SERVE_TICKS=3 → ballCenter pulses 1 cycle; ballHold stays 1 through 3 ticks, then drops to 0 on the 3rd tick edge; state is RALLY.
- In RALLY with HITS_PER_LEVEL=4, drive 13 paddleHit pulses → speedLevel steps 1, 2, 3 at hits 4, 8 and 12, and stays 3 at hit 13.
- goalRight in RALLY → p1score 0→1, serveDir=1, ballHold=1. After POINT_TICKS ticks, ballCenter pulses and speedLevel=0.
- goalLeft and goalRight in the same cycle → only p2score increments; serveDir=0.
- With WIN_SCORE=2, two goalLeft rallies → winner=10, state OVER, p2score=2. Further goals are ignored. start → scores 0, winner 00, serveDir=1, state SERVE.
- Assert resetB=0 mid-SERVE with a score of 1–1 → all outputs return to their reset values immediately; a tick without start leaves the state at IDLE.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared types and encodings for the Speed Pong match sequencer
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SERVE,
        RALLY,
        POINT,
        OVER
    } match_state_t;

    localparam logic SERVE_LEFT  = 1'b0;
    localparam logic SERVE_RIGHT = 1'b1;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam logic [1:0] SPEED_MAX = 2'd3;

endpackage

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - 8-bit loadable down-counter advanced by the tick strobe
module tick_timer (
    input  logic       clk,
    input  logic       resetB,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       tick,
    output logic       done
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_value;
        end else if (tick && (count != 8'd0)) begin
            count <= count - 8'd1;
        end
    end

    // done marks the edge that consumes the final tick, so the owner can
    // change state on that same edge; it must not depend on load.
    assign done = tick && (count == 8'd1);

endmodule

// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - rally lifecycle, scoring and speed-level sequencer
module pong_match_ctrl #(
    parameter int WIN_SCORE      = 7,
    parameter int SERVE_TICKS    = 100,
    parameter int POINT_TICKS    = 60,
    parameter int HITS_PER_LEVEL = 4
) (
    input  logic       clk,
    input  logic       resetB,
    input  logic       tick,
    input  logic       start,
    input  logic       goalLeft,
    input  logic       goalRight,
    input  logic       paddleHit,
    output logic       ballHold,
    output logic       ballCenter,
    output logic       serveDir,
    output logic [1:0] speedLevel,
    output logic [3:0] p1score,
    output logic [3:0] p2score,
    output logic [1:0] winner
);

    import pong_pkg::*;

    localparam logic [3:0] WIN_Q     = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_Q   = 8'(SERVE_TICKS);
    localparam logic [7:0] POINT_Q   = 8'(POINT_TICKS);
    localparam logic [3:0] HITS_LAST = 4'(HITS_PER_LEVEL - 1);

    match_state_t state_q;
    match_state_t state_d;

    logic       hold_d;
    logic       center_d;
    logic       dir_d;
    logic [1:0] speed_d;
    logic [3:0] p1_d;
    logic [3:0] p2_d;
    logic [1:0] winner_d;
    logic [3:0] hits_q;
    logic [3:0] hits_d;

    logic       timer_load;
    logic [7:0] timer_value;
    logic       timer_done;

    tick_timer u_timer (
        .clk        (clk),
        .resetB     (resetB),
        .load       (timer_load),
        .load_value (timer_value),
        .tick       (tick),
        .done       (timer_done)
    );

    always_ff @(posedge clk or negedge resetB) begin
        if (!resetB) begin
            state_q    <= IDLE;
            ballHold   <= 1'b1;
            ballCenter <= 1'b0;
            serveDir   <= SERVE_RIGHT;
            speedLevel <= 2'd0;
            p1score    <= 4'd0;
            p2score    <= 4'd0;
            winner     <= WIN_NONE;
            hits_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            ballHold   <= hold_d;
            ballCenter <= center_d;
            serveDir   <= dir_d;
            speedLevel <= speed_d;
            p1score    <= p1_d;
            p2score    <= p2_d;
            winner     <= winner_d;
            hits_q     <= hits_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        center_d    = 1'b0;
        dir_d       = serveDir;
        speed_d     = speedLevel;
        p1_d        = p1score;
        p2_d        = p2score;
        winner_d    = winner;
        hits_d      = hits_q;
        timer_load  = 1'b0;
        timer_value = SERVE_Q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SERVE;
                    p1_d    = 4'd0;
                    p2_d    = 4'd0;
                end
            end
            SERVE: begin
                if (timer_done) begin
                    state_d = RALLY;
                end
            end
            RALLY: begin
                // goalLeft outranks goalRight, and any goal swallows a same-cycle hit
                if (goalLeft) begin
                    p2_d        = p2score + 4'd1;
                    dir_d       = SERVE_LEFT;
                    state_d     = POINT;
                    timer_load  = 1'b1;
                    timer_value = POINT_Q;
                end else if (goalRight) begin
                    p1_d        = p1score + 4'd1;
                    dir_d       = SERVE_RIGHT;
                    state_d     = POINT;
                    timer_load  = 1'b1;
                    timer_value = POINT_Q;
                end else if (paddleHit) begin
                    if (hits_q == HITS_LAST) begin
                        hits_d = 4'd0;
                        if (speedLevel != SPEED_MAX) begin
                            speed_d = speedLevel + 2'd1;
                        end
                    end else begin
                        hits_d = hits_q + 4'd1;
                    end
                end
            end
            POINT: begin
                if (p1score == WIN_Q) begin
                    state_d  = OVER;
                    winner_d = WIN_P1;
                end else if (p2score == WIN_Q) begin
                    state_d  = OVER;
                    winner_d = WIN_P2;
                end else if (timer_done) begin
                    state_d = SERVE;
                end
            end
            OVER: begin
                if (start) begin
                    state_d  = SERVE;
                    p1_d     = 4'd0;
                    p2_d     = 4'd0;
                    winner_d = WIN_NONE;
                    dir_d    = SERVE_RIGHT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every path into SERVE recentres the ball and restarts the rally pace.
        if ((state_d == SERVE) && (state_q != SERVE)) begin
            center_d    = 1'b1;
            timer_load  = 1'b1;
            timer_value = SERVE_Q;
            speed_d     = 2'd0;
            hits_d      = 4'd0;
        end

        hold_d = (state_d != RALLY);
    end

endmodule
